// File: rtl/disp_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with a per-slot anode blanking gap.
// Shadow-buffered digit codes; nibble_o and an_o are registered and change on the index-advance edge.
module disp_scan_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load,
  output logic [3:0]            nibble_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  slot_tick
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_INIT = CW'(BLANK_CYC);
  localparam logic          AN_POL     = (AN_ACT_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_POL}};

  logic [N_DIGITS-1:0][3:0] shadow;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            blank;
  logic [IW-1:0]            idx;

  logic                     term;
  logic [CW-1:0]            cnt_nxt;
  logic [CW-1:0]            blank_nxt;
  logic [IW-1:0]            idx_nxt;
  logic [N_DIGITS-1:0]      sel_hot;
  logic                     lit;
  logic [N_DIGITS-1:0]      an_nxt;
  logic [3:0]               nib_nxt;

  always_comb begin
    term    = (cnt == CNT_LAST);
    cnt_nxt = term ? '0 : cnt + 1'b1;
    idx_nxt = idx;
    if (term) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    blank_nxt = '0;
    if (term) begin
      blank_nxt = BLANK_INIT;
    end else if (blank != '0) begin
      blank_nxt = blank - 1'b1;
    end
    // Outputs look at the post-edge index so they move together with idx
    sel_hot = N_DIGITS'(1) << idx_nxt;
    lit     = digit_en[idx_nxt] && (blank_nxt == '0);
    an_nxt  = lit ? (sel_hot ^ AN_OFF) : AN_OFF;
    nib_nxt = shadow[idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      cnt       <= '0;
      idx       <= '0;
      blank     <= BLANK_INIT;
      nibble_o  <= '0;
      an_o      <= AN_OFF;
      slot_tick <= 1'b0;
    end else begin
      if (load) begin
        shadow <= digits_i;
      end
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      blank     <= blank_nxt;
      nibble_o  <= nib_nxt;
      an_o      <= an_nxt;
      slot_tick <= term;
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux: blanked active-low instance
// and a gapless active-high instance driven from the same inputs.
module tb_disp_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic        load;

  logic [3:0]  nib_a;
  logic [3:0]  an_a;
  logic        tick_a;
  logic [3:0]  nib_b;
  logic [3:0]  an_b;
  logic        tick_b;

  int k;
  int n_chk;
  int n_pass;

  always #5 clk = ~clk;

  disp_scan_mux #(
    .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .AN_ACT_LOW(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .digits_i(digits), .digit_en(digit_en),
    .load(load), .nibble_o(nib_a), .an_o(an_a), .slot_tick(tick_a)
  );

  disp_scan_mux #(
    .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(0), .AN_ACT_LOW(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .digits_i(digits), .digit_en(digit_en),
    .load(load), .nibble_o(nib_b), .an_o(an_b), .slot_tick(tick_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    digits   = 16'h4321;
    digit_en = 4'hF;
    load     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (nib_a !== 4'h0) $display("FAIL reset_nib got %h exp 0", nib_a);
    else n_pass++;
    n_chk++;
    if (an_a !== 4'hF) $display("FAIL reset_an_a got %b exp 1111", an_a);
    else n_pass++;
    n_chk++;
    if (tick_a !== 1'b0) $display("FAIL reset_tick got %b exp 0", tick_a);
    else n_pass++;
    n_chk++;
    if (an_b !== 4'h0) $display("FAIL reset_an_b got %b exp 0000", an_b);
    else n_pass++;
  endtask

  task automatic test_scan();
    int idx;
    int p;
    logic [3:0] e_nib;
    logic [3:0] e_an;
    logic [3:0] e_anb;
    rst_n = 1'b1;
    load  = 1'b1;
    k     = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      load  = 1'b0;
      idx   = (k / 4) % 4;
      p     = k % 4;
      e_nib = (k == 1) ? 4'h0 : 4'(idx + 1);
      e_an  = (p == 0) ? 4'hF : (4'hF ^ (4'b0001 << idx));
      e_anb = 4'b0001 << idx;
      n_chk++;
      if (nib_a !== e_nib)
        $display("FAIL scan_nib k=%0d got %h exp %h", k, nib_a, e_nib);
      else n_pass++;
      n_chk++;
      if (an_a !== e_an)
        $display("FAIL scan_an k=%0d got %b exp %b", k, an_a, e_an);
      else n_pass++;
      n_chk++;
      if (tick_a !== (p == 0))
        $display("FAIL scan_tick k=%0d got %b exp %b", k, tick_a, p == 0);
      else n_pass++;
      n_chk++;
      if (an_b !== e_anb)
        $display("FAIL scan_an_b k=%0d got %b exp %b", k, an_b, e_anb);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    step();
    n_chk++;
    if (nib_a !== 4'h1) $display("FAIL wrap_nib got %h exp 1", nib_a);
    else n_pass++;
    n_chk++;
    if (an_a !== 4'hF) $display("FAIL wrap_blank got %b exp 1111", an_a);
    else n_pass++;
    n_chk++;
    if (tick_a !== 1'b1) $display("FAIL wrap_tick got %b exp 1", tick_a);
    else n_pass++;
    n_chk++;
    if (an_b !== 4'b0001) $display("FAIL wrap_an_b got %b exp 0001", an_b);
    else n_pass++;
    step();
    n_chk++;
    if (an_a !== 4'b1110) $display("FAIL wrap_lit got %b exp 1110", an_a);
    else n_pass++;
    n_chk++;
    if (tick_a !== 1'b0) $display("FAIL wrap_tick_low got %b exp 0", tick_a);
    else n_pass++;
  endtask

  task automatic test_enable();
    int idx;
    int p;
    logic [15:0] d;
    logic [3:0]  e_nib;
    logic [3:0]  e_an;
    d      = 16'hABCD;
    digits = d;
    load   = 1'b1;
    step();
    load     = 1'b0;
    digit_en = 4'b0101;
    n_chk++;
    if (nib_a !== 4'h1) $display("FAIL en_old_nib got %h exp 1", nib_a);
    else n_pass++;
    for (int i = 0; i < 15; i++) begin
      step();
      idx   = (k / 4) % 4;
      p     = k % 4;
      e_nib = d[idx*4 +: 4];
      e_an  = (p == 0 || !digit_en[idx]) ? 4'hF : (4'hF ^ (4'b0001 << idx));
      n_chk++;
      if (nib_a !== e_nib)
        $display("FAIL en_nib k=%0d got %h exp %h", k, nib_a, e_nib);
      else n_pass++;
      n_chk++;
      if (an_a !== e_an)
        $display("FAIL en_an k=%0d got %b exp %b", k, an_a, e_an);
      else n_pass++;
    end
  endtask

  task automatic test_load_terminal();
    digit_en = 4'hF;
    step();
    step();
    digits = 16'h0F0F;
    load   = 1'b1;
    step();
    load = 1'b0;
    n_chk++;
    if (nib_a !== 4'hC) $display("FAIL ld_old_nib got %h exp c", nib_a);
    else n_pass++;
    n_chk++;
    if (tick_a !== 1'b1) $display("FAIL ld_tick got %b exp 1", tick_a);
    else n_pass++;
    step();
    n_chk++;
    if (nib_a !== 4'h0) $display("FAIL ld_new_nib got %h exp 0", nib_a);
    else n_pass++;
    n_chk++;
    if (an_a !== 4'b1101) $display("FAIL ld_an got %b exp 1101", an_a);
    else n_pass++;
    digits = 16'h1234;
    step();
    step();
    n_chk++;
    if (nib_a !== 4'h0) $display("FAIL ld_no_tear got %h exp 0", nib_a);
    else n_pass++;
    step();
    n_chk++;
    if (nib_a !== 4'hF) $display("FAIL ld_slot2_nib got %h exp f", nib_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (nib_a !== 4'h0) $display("FAIL rstmid_nib got %h exp 0", nib_a);
    else n_pass++;
    n_chk++;
    if (an_a !== 4'hF) $display("FAIL rstmid_an got %b exp 1111", an_a);
    else n_pass++;
    n_chk++;
    if (an_b !== 4'h0) $display("FAIL rstmid_an_b got %b exp 0000", an_b);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k     = 0;
    #1;
    n_chk++;
    if (an_a !== 4'hF) $display("FAIL rel_gap got %b exp 1111", an_a);
    else n_pass++;
    step();
    n_chk++;
    if (nib_a !== 4'h0) $display("FAIL rel_nib got %h exp 0", nib_a);
    else n_pass++;
    n_chk++;
    if (an_a !== 4'b1110) $display("FAIL rel_an got %b exp 1110", an_a);
    else n_pass++;
    step();
    step();
    step();
    n_chk++;
    if (nib_a !== 4'h0) $display("FAIL rel_cleared got %h exp 0", nib_a);
    else n_pass++;
    n_chk++;
    if (tick_a !== 1'b1) $display("FAIL rel_tick got %b exp 1", tick_a);
    else n_pass++;
  endtask

  task automatic test_no_blank();
    int idx;
    int p;
    logic [15:0] d;
    logic [3:0]  e_nib;
    logic [3:0]  e_an;
    d      = 16'h8765;
    digits = d;
    load   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      load  = 1'b0;
      idx   = (k / 4) % 4;
      p     = k % 4;
      e_nib = (k == 5) ? 4'h0 : d[idx*4 +: 4];
      e_an  = 4'b0001 << idx;
      n_chk++;
      if (an_b !== e_an)
        $display("FAIL nb_an k=%0d got %b exp %b", k, an_b, e_an);
      else n_pass++;
      n_chk++;
      if (nib_b !== e_nib)
        $display("FAIL nb_nib k=%0d got %h exp %h", k, nib_b, e_nib);
      else n_pass++;
      n_chk++;
      if (tick_b !== (p == 0))
        $display("FAIL nb_tick k=%0d got %b exp %b", k, tick_b, p == 0);
      else n_pass++;
    end
  endtask

  initial begin
    k      = 0;
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_scan();
    test_wrap();
    test_enable();
    test_load_terminal();
    test_reset_mid();
    test_no_blank();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
